// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings for the datapath instruction-sequencing controller:
// opcode/op fields, FSM state codes, writeback selects and ALU/shifter controls.
package datapath_ctrl_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_WRITE_IMM = 3'd2;
  localparam logic [2:0] S_GET_A     = 3'd3;
  localparam logic [2:0] S_GET_B     = 3'd4;
  localparam logic [2:0] S_ALU       = 3'd5;
  localparam logic [2:0] S_WRITE_REG = 3'd6;

  localparam logic [3:0] VSEL_MDATA = 4'b1000;
  localparam logic [3:0] VSEL_IMM8  = 4'b0100;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_DOUT  = 4'b0001;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } instr_cls_e;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/datapath_ctrl_fsm_instr_dec.sv
// Combinational instruction decode: field extraction, immediate sign extension
// and instruction class (illegal encodings fall into CLS_ILLEGAL).
module instr_dec (
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [2:0]  cls,
  output logic [1:0]  alu_op,
  output logic        asel_zero
);
  import datapath_ctrl_pkg::*;

  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm5 = sext5(ir[4:0]);
  assign sximm8 = sext8(ir[7:0]);

  always_comb begin
    cls       = CLS_ILLEGAL;
    alu_op    = ALU_ADD;
    asel_zero = 1'b0;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM) begin
        cls = CLS_MOV_IMM;
      end else if (op == OP_MOV_REG) begin
        // MOV reg goes through the ALU as 0 + shifted Rm
        cls       = CLS_MOV_REG;
        asel_zero = 1'b1;
      end
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD: begin
          cls    = CLS_ADD;
          alu_op = ALU_ADD;
        end
        OP_CMP: begin
          cls    = CLS_CMP;
          alu_op = ALU_SUB;
        end
        OP_AND: begin
          cls    = CLS_AND;
          alu_op = ALU_AND;
        end
        default: begin
          cls    = CLS_MVN;
          alu_op = ALU_NOTB;
        end
      endcase
    end
  end

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// Moore sequencer for the register-file/shifter/ALU datapath: latches one
// instruction per start handshake and steps the datapath controls from state and IR.
//
// state     | meaning
// WAIT      | idle, w=1, accepts s and captures instr into IR
// DECODE    | classify IR; illegal pulses here and returns to WAIT
// WRITE_IMM | write sximm8 to Rn
// GET_A     | read Rn into A
// GET_B     | read Rm into B
// ALU       | shift/ALU; CMP loads status, others load C
// WRITE_REG | write datapath_out to Rd
module datapath_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        illegal
);
  import datapath_ctrl_pkg::*;

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] rn, rd, rm;
  logic [1:0] sh;
  logic [2:0] cls;
  logic [1:0] dec_alu_op;
  logic       dec_asel_zero;

  instr_dec u_instr_dec (
    .ir        (ir_q),
    .rn        (rn),
    .rd        (rd),
    .rm        (rm),
    .sh        (sh),
    .sximm5    (sximm5),
    .sximm8    (sximm8),
    .cls       (cls),
    .alu_op    (dec_alu_op),
    .asel_zero (dec_asel_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          CLS_MOV_IMM:               state_d = S_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN:      state_d = S_GET_B;
          CLS_ADD, CLS_CMP, CLS_AND: state_d = S_GET_A;
          default:                   state_d = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = (cls == CLS_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = VSEL_DOUT;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;
    loadc    = 1'b0;
    loads    = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_WAIT: w = 1'b1;
      S_DECODE: illegal = (cls == CLS_ILLEGAL);
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = sh;
        ALUop = dec_alu_op;
        asel  = dec_asel_zero;
        // CMP only updates status; everything else captures the result in C
        if (cls == CLS_CMP) begin
          loads = 1'b1;
        end else begin
          loadc = 1'b1;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = VSEL_DOUT;
        write    = 1'b1;
      end
      default: w = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Directed bench for datapath_ctrl_fsm: table of per-instruction expectations
// plus hand sequences for reset abort, reset-vs-start and back-to-back issue.
module tb_datapath_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic        write;
  logic [3:0]  vsel;
  logic        loada, loadb, asel, bsel;
  logic [1:0]  shift, ALUop;
  logic        loadc, loads;
  logic [15:0] sximm5, sximm8;
  logic        illegal;

  datapath_ctrl_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .instr    (instr),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .loadc    (loadc),
    .loads    (loads),
    .sximm5   (sximm5),
    .sximm8   (sximm8),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          busy;
    int          nwr;
    logic [2:0]  wn;
    logic [3:0]  vs;
    int          nla;
    int          nlb;
    int          nlc;
    int          nls;
    int          nil;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [1:0]  alu;
    logic [1:0]  sh;
    logic        as;
  } vec_t;

  vec_t vecs[9];

  int n_cmp = 0;
  int n_bad = 0;

  int         obs_busy, obs_nwr, obs_nla, obs_nlb, obs_nlc, obs_nls, obs_nil, obs_bsel;
  logic [2:0] obs_wn, obs_ra, obs_rb;
  logic [3:0] obs_vs;
  logic [1:0] obs_alu, obs_sh;
  logic       obs_as;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one instruction with a single-cycle s pulse, scramble instr while
  // busy, and record what the controller does until w returns high.
  task automatic exec(input logic [15:0] ins);
    obs_busy = 0; obs_nwr = 0; obs_nla = 0; obs_nlb = 0; obs_nlc = 0;
    obs_nls = 0; obs_nil = 0; obs_bsel = 0;
    obs_wn = '0; obs_vs = '0; obs_ra = '0; obs_rb = '0;
    obs_alu = '0; obs_sh = '0; obs_as = 1'b0;
    @(negedge clk);
    instr = ins;
    s     = 1'b1;
    @(posedge clk);
    #1;
    s     = 1'b0;
    instr = 16'hFFFF;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (w) break;
      obs_busy++;
      if (write) begin obs_nwr++; obs_wn = writenum; obs_vs = vsel; end
      if (loada) begin obs_nla++; obs_ra = readnum; end
      if (loadb) begin obs_nlb++; obs_rb = readnum; end
      if (loadc) obs_nlc++;
      if (loads) obs_nls++;
      if (loadc || loads) begin obs_alu = ALUop; obs_sh = shift; obs_as = asel; end
      if (illegal) obs_nil++;
      if (bsel) obs_bsel++;
    end
    chk("exec_returned_to_wait", int'(w), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w_pat, wr_pat;
    logic [2:0] wn3, wn6;
    logic [1:0] alu2;
    logic [15:0] sx8_6, sx5_0;
    int         la_any;

    vecs[0] = '{16'hD1FC, 2, 1, 3'd1, 4'b0100, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0};
    vecs[1] = '{16'hA153, 5, 1, 3'd2, 4'b0001, 1, 1, 1, 0, 0, 3'd1, 3'd3, 2'b00, 2'b10, 1'b0};
    vecs[2] = '{16'hA903, 4, 0, 3'd0, 4'b0000, 1, 1, 0, 1, 0, 3'd1, 3'd3, 2'b01, 2'b00, 1'b0};
    vecs[3] = '{16'hB8A3, 4, 1, 3'd5, 4'b0001, 0, 1, 1, 0, 0, 3'd0, 3'd3, 2'b11, 2'b00, 1'b0};
    vecs[4] = '{16'h0000, 1, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0};
    vecs[5] = '{16'hB287, 5, 1, 3'd4, 4'b0001, 1, 1, 1, 0, 0, 3'd2, 3'd7, 2'b10, 2'b00, 1'b0};
    vecs[6] = '{16'hC0CA, 4, 1, 3'd6, 4'b0001, 0, 1, 1, 0, 0, 3'd0, 3'd2, 2'b00, 2'b01, 1'b1};
    vecs[7] = '{16'hC800, 1, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0};
    vecs[8] = '{16'hE000, 1, 0, 3'd0, 4'b0000, 0, 0, 0, 0, 1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0};

    reset = 1'b1;
    s     = 1'b0;
    instr = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_w", int'(w), 1);
    chk("rst_write", int'(write), 0);
    chk("rst_loads_any", int'({loada, loadb, loadc, loads}), 0);
    chk("rst_asel_bsel_ill", int'({asel, bsel, illegal}), 0);
    chk("rst_readnum", int'(readnum), 0);
    chk("rst_writenum", int'(writenum), 0);
    chk("rst_vsel", int'(vsel), 4'b0001);
    chk("rst_shift", int'(shift), 0);
    chk("rst_aluop", int'(ALUop), 0);
    chk("rst_sximm8", int'(sximm8), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_w", int'(w), 1);

    foreach (vecs[i]) begin
      exec(vecs[i].instr);
      chk($sformatf("v%0d_busy", i), obs_busy, vecs[i].busy);
      chk($sformatf("v%0d_nwrite", i), obs_nwr, vecs[i].nwr);
      chk($sformatf("v%0d_writenum", i), int'(obs_wn), int'(vecs[i].wn));
      chk($sformatf("v%0d_vsel", i), int'(obs_vs), int'(vecs[i].vs));
      chk($sformatf("v%0d_nloada", i), obs_nla, vecs[i].nla);
      chk($sformatf("v%0d_nloadb", i), obs_nlb, vecs[i].nlb);
      chk($sformatf("v%0d_nloadc", i), obs_nlc, vecs[i].nlc);
      chk($sformatf("v%0d_nloads", i), obs_nls, vecs[i].nls);
      chk($sformatf("v%0d_nillegal", i), obs_nil, vecs[i].nil);
      chk($sformatf("v%0d_readnum_a", i), int'(obs_ra), int'(vecs[i].ra));
      chk($sformatf("v%0d_readnum_b", i), int'(obs_rb), int'(vecs[i].rb));
      chk($sformatf("v%0d_aluop", i), int'(obs_alu), int'(vecs[i].alu));
      chk($sformatf("v%0d_shift", i), int'(obs_sh), int'(vecs[i].sh));
      chk($sformatf("v%0d_asel", i), int'(obs_as), int'(vecs[i].as));
      chk($sformatf("v%0d_bsel_cycles", i), obs_bsel, 0);
      if (vecs[i].instr == 16'hA153) begin
        // IR is held in WAIT, so the immediates still reflect the ADD
        chk("add_sximm5_hold", int'(sximm5), 16'hFFF3);
        chk("add_sximm8_hold", int'(sximm8), 16'h0053);
      end
    end

    // Reset in GET_B of an ADD aborts immediately.
    @(negedge clk);
    instr = 16'hA153;
    s     = 1'b1;
    @(posedge clk);
    #1 s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("abort_in_getb_loadb", int'(loadb), 1);
    reset = 1'b1;
    #1;
    chk("abort_w", int'(w), 1);
    chk("abort_write", int'(write), 0);
    chk("abort_loada_loadb", int'({loada, loadb}), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_idle%0d_w", c), int'(w), 1);
      chk($sformatf("abort_idle%0d_write", c), int'(write), 0);
    end

    // Reset on the same edge as s wins; IR stays cleared.
    @(negedge clk);
    reset = 1'b1;
    s     = 1'b1;
    instr = 16'hA153;
    @(posedge clk);
    #1;
    chk("rst_vs_s_w", int'(w), 1);
    @(negedge clk);
    reset = 1'b0;
    s     = 1'b0;
    @(negedge clk);
    chk("rst_vs_s_w_after", int'(w), 1);
    chk("rst_vs_s_ir_clear", int'(sximm8), 0);

    // Back-to-back: MVN with s held, instr changed to MOV imm while busy.
    w_pat = '0; wr_pat = '0; wn3 = '0; wn6 = '0; alu2 = '0;
    sx8_6 = '0; sx5_0 = '0; la_any = 0;
    @(negedge clk);
    instr = 16'hB8A3;
    s     = 1'b1;
    @(posedge clk);
    #1 instr = 16'hD1FC;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      w_pat[c]  = w;
      wr_pat[c] = write;
      if (loada) la_any++;
      if (c == 0) sx5_0 = sximm5;
      if (c == 2) alu2 = ALUop;
      if (c == 3) wn3 = writenum;
      if (c == 5) s = 1'b0;
      if (c == 6) begin wn6 = writenum; sx8_6 = sximm8; end
    end
    chk("b2b_w_pattern", int'(w_pat), 8'h90);
    chk("b2b_write_pattern", int'(wr_pat), 8'h48);
    chk("b2b_mvn_aluop", int'(alu2), 2'b11);
    chk("b2b_mvn_writenum", int'(wn3), 5);
    chk("b2b_mvn_sximm5", int'(sx5_0), 16'h0003);
    chk("b2b_no_loada", la_any, 0);
    chk("b2b_mov_writenum", int'(wn6), 1);
    chk("b2b_mov_sximm8", int'(sx8_6), 16'hFFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl_fsm.md
Name: datapath_ctrl_fsm

Overview:
- Instruction-sequencing controller for the 16-bit register-file/shifter/ALU datapath.
- Accepts one instruction on a start handshake and latches it into an internal instruction register (IR).
- Decodes the IR and steps a Moore FSM that drives every datapath control: readnum, writenum, write, vsel, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, plus the sign-extended immediates.
- Sits between the instruction source and the datapath.

Parameters:
- none (16-bit ISA, 8 registers, fixed encoding)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
s  in  1  start; sampled only in WAIT
instr  in  16  instruction; captured into IR on the edge that accepts s
w  out  1  1 = idle/ready (WAIT state only)
readnum  out  3  register-file read address
writenum  out  3  register-file write address
write  out  1  register-file write enable
vsel  out  4  one-hot writeback select: 1000 mdata, 0100 sximm8, 0010 PC, 0001 datapath_out
loada  out  1  load A register
loadb  out  1  load B register
asel  out  1  1 = A operand forced to 0
bsel  out  1  1 = B operand is sximm5
shift  out  2  shifter control
ALUop  out  2  00 add, 01 sub, 10 and, 11 not B
loadc  out  1  load C (datapath_out)
loads  out  1  load Z/N/V status
sximm5  out  16  sign-extended IR[4:0]
sximm8  out  16  sign-extended IR[7:0]
illegal  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Encoding:
  - [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] im8.
  - 110/10 MOV Rn,#im8.
  - 110/00 MOV Rd,Rm{,sh}.
  - 101/00 ADD Rd,Rn,Rm{,sh}.
  - 101/01 CMP Rn,Rm{,sh}.
  - 101/10 AND Rd,Rn,Rm{,sh}.
  - 101/11 MVN Rd,Rm{,sh}.
  - Anything else is illegal.
- Reset:
  - state=WAIT, IR=0.
  - Outputs: w=1; write, loada, loadb, loadc, loads, asel, bsel, illegal = 0; readnum=writenum=0; vsel=0001; shift=00; ALUop=00.
  - Asserting reset mid-instruction aborts it with no further write or load.
- All control outputs are a pure function of state and IR (Moore). Any control not listed for a state holds its reset value.
- sximm5 and sximm8 are driven continuously from IR. bsel is always 0 for this ISA.
- States and controls:
  - WAIT: w=1. If s=1, capture IR<=instr and go to DECODE; otherwise stay.
  - DECODE:
    - MOV imm -> WRITE_IMM.
    - MOV reg or MVN -> GET_B.
    - ADD, CMP or AND -> GET_A.
    - Illegal -> WAIT with illegal=1 for this cycle.
  - WRITE_IMM: writenum=Rn, vsel=0100, write=1 -> WAIT.
  - GET_A: readnum=Rn, loada=1 -> GET_B.
  - GET_B: readnum=Rm, loadb=1 -> ALU.
  - ALU: shift=sh.
    - ADD: ALUop=00.
    - AND: ALUop=10.
    - MVN: ALUop=11.
    - MOV reg: ALUop=00 and asel=1.
    - CMP: ALUop=01, loads=1, loadc=0, then -> WAIT.
    - All others: loadc=1, loads=0, then -> WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=0001, write=1 -> WAIT.
- Busy cycles (w=0):
  - MOV imm: 2.
  - MOV reg, MVN, CMP: 4.
  - ADD, AND: 5.
  - Illegal: 1.
- s or instr changes while busy are ignored.
- s held high on return to WAIT starts the next instruction immediately: back-to-back issue with exactly one w=1 cycle between instructions.
- Reset asserted on the same edge as s wins.

Decomposition:
- Shared package datapath_ctrl_pkg holds:
  - opcode/op constants;
  - state enum (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG);
  - one-hot vsel constants;
  - ALUop and shift constants.
- One combinational sub-module, instr_dec, performs IR field extraction, sign extension and legality/class decode.
- The FSM lives in datapath_ctrl_fsm.

Test Plan:
- Reset then idle: reset=1 mid-ADD (in GET_B) -> w=1, write=0, loada=loadb=0 immediately; state WAIT after release.
- MOV R1,#-4 (instr=16'hD1FC, s=1):
  - w=0 for 2 cycles.
  - Exactly one write=1 cycle, in which writenum=001, vsel=0100, sximm8=16'hFFFC.
- ADD R2,R1,R3,LSR#1 (16'hA153):
  - Cycle sequence: loada with readnum=001; then loadb with readnum=011; then loadc with shift=10, ALUop=00, asel=0; then write with writenum=010, vsel=0001.
  - w=0 for 5 cycles.
- CMP R1,R3 (16'hA903):
  - ALU cycle has ALUop=01, loads=1, loadc=0.
  - No write cycle; w=0 for 4 cycles.
- MVN R5,R3 (16'hB8A3) back-to-back with held s, followed by MOV R1,#-4:
  - No GET_A cycle; ALUop=11; write with writenum=101.
  - Second instruction's DECODE begins one cycle after WAIT.
  - instr toggled while busy has no effect.
- Illegal instr=16'h0000:
  - illegal=1 for exactly one cycle (DECODE).
  - No load/write asserted; w back to 1 next cycle.
